// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the 8-bit PRBS pattern family.
//
// Contents:
//   POLY8           tap mask for x^8+x^6+x^5+x^4+1 with a left shift, so the
//                   feedback is s[7]^s[5]^s[4]^s[3].
//   state_t         checker synchronisation states.
//   prbs8_next_bit  next inserted bit for a given register value. The
//                   generator and the checker both call this, so their tap
//                   definitions stay identical.
package prbs_pkg;

    localparam logic [7:0] POLY8 = 8'hB8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Parity of the tapped bits. The result is the bit that is shifted into
    // s[0] on the next update.
    function automatic logic prbs8_next_bit(input logic [7:0] s);
        return ^(s & POLY8);
    endfunction

endpackage

// File: rtl/prbs8_checker.sv
// prbs8_checker -- self-synchronising serial checker for the 8-bit PRBS
// stream (x^8+x^6+x^5+x^4+1), placed at the loopback/BIST sink.
//
// Operation:
//   HUNT   : shift in 8 received bits to seed the local register.
//   VERIFY : keep shifting received bits in (open loop) and count
//            consecutive correct predictions. Reaching LOCK_THRESH moves
//            to LOCKED.
//   LOCKED : run the register closed loop from its own prediction and count
//            mismatching received bits. LOSS_THRESH consecutive mismatches
//            drop back to HUNT.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   qualifies in_bit; when low every piece of state holds
//   in_bit     in   received PRBS bit
//   clr_count  in   synchronous clear of err_count; wins over an increment
//   locked     out  high while in LOCKED
//   err_pulse  out  one-cycle pulse per mismatched bit while LOCKED
//   sync_loss  out  one-cycle pulse on the LOCKED->HUNT transition
//   err_count  out  saturating count of mismatches seen while LOCKED
//
// All outputs are registered. A pulse appears on the cycle after the valid
// bit that caused it.
module prbs8_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH = 16,   // 1..255
    parameter int LOSS_THRESH = 4,    // 1..15
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
    localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

    state_t           state_reg, state_next;
    logic [7:0]       s_reg, s_next;
    logic [2:0]       fill_reg, fill_next;
    logic [7:0]       run_reg, run_next;
    logic [3:0]       miss_reg, miss_next;
    logic             locked_reg, locked_next;
    logic             err_pulse_reg, err_pulse_next;
    logic             sync_loss_reg, sync_loss_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;

    logic       pred;
    logic [7:0] s_shift;
    logic [7:0] run_inc;
    logic [3:0] miss_inc;

    // The prediction comes from the register before this bit is shifted in.
    assign pred     = prbs8_next_bit(s_reg);
    assign s_shift  = {s_reg[6:0], in_bit};
    assign run_inc  = run_reg + 8'd1;
    assign miss_inc = miss_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        s_next         = s_reg;
        fill_next      = fill_reg;
        run_next       = run_reg;
        miss_next      = miss_reg;
        err_count_next = err_count_reg;
        err_pulse_next = 1'b0;
        sync_loss_next = 1'b0;

        if (in_valid) begin
            case (state_reg)
                HUNT: begin
                    s_next    = s_shift;
                    fill_next = fill_reg + 3'd1;
                    if (fill_reg == 3'd7) begin
                        state_next = VERIFY;
                        run_next   = 8'd0;
                    end
                end

                VERIFY: begin
                    // Open loop: the register always holds the last 8
                    // received bits, so a bad seed is flushed out by itself.
                    s_next = s_shift;
                    // An all-zero register would predict zeros forever, so it
                    // never counts; a stuck-at-0 line therefore cannot lock.
                    if ((in_bit == pred) && (s_shift != 8'h00)) begin
                        run_next = run_inc;
                        if (run_inc == LOCK_T) begin
                            state_next = LOCKED;
                            miss_next  = 4'd0;
                        end
                    end else begin
                        run_next = 8'd0;
                    end
                end

                LOCKED: begin
                    // Closed loop: a single flipped line bit produces exactly
                    // one error and does not corrupt later predictions.
                    s_next = {s_reg[6:0], pred};
                    if (in_bit != pred) begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != {CNT_W{1'b1}}) begin
                            err_count_next = err_count_reg + CNT_W'(1);
                        end
                        miss_next = miss_inc;
                        if (miss_inc == LOSS_T) begin
                            state_next     = HUNT;
                            sync_loss_next = 1'b1;
                            fill_next      = 3'd0;
                        end
                    end else begin
                        miss_next = 4'd0;
                    end
                end

                default: begin
                    state_next = HUNT;
                    fill_next  = 3'd0;
                end
            endcase
        end

        if (clr_count) begin
            err_count_next = '0;
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= HUNT;
            s_reg         <= 8'h00;
            fill_reg      <= 3'd0;
            run_reg       <= 8'd0;
            miss_reg      <= 4'd0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            sync_loss_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            fill_reg      <= fill_next;
            run_reg       <= run_next;
            miss_reg      <= miss_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            sync_loss_reg <= sync_loss_next;
            err_count_reg <= err_count_next;
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign sync_loss = sync_loss_reg;
    assign err_count = err_count_reg;

endmodule
